// File: rtl/start_seq_ctrl.sv
// rtl/start_seq_ctrl.sv - start-triggered IDLE/STATE1/STATE2/STATE3 sequencer
//
// Purpose: drives the registered 2-bit s_bits state bus through
//   IDLE -> STATE1 -> STATE2 -> STATE3 (dwell+1 cycles) -> IDLE
// on an accepted start, with stall/abort in STATE2/STATE3, a done pulse on
// normal completion and a start_err pulse for a start issued while busy.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     sequence request
//   abort     terminate sequence (STATE2/STATE3 only)
//   stall     hold current state (STATE2/STATE3 only)
//   dwell     extra STATE3 cycles, latched on an accepted start
//   s_bits    registered state bus
//   busy      s_bits != IDLE
//   done      one-cycle pulse on the first IDLE cycle after normal exit
//   start_err one-cycle pulse after a start rejected while busy
//
// Optional: define START_SEQ_CTRL_ASSERT_EN to compile in embedded
// concurrent assertions and a cover; behaviour is identical either way.

module start_seq_ctrl #(
  parameter int          DWELL_W = 4,
  parameter logic [1:0]  IDLE    = 2'b00,
  parameter logic [1:0]  STATE1  = 2'b01,
  parameter logic [1:0]  STATE2  = 2'b10,
  parameter logic [1:0]  STATE3  = 2'b11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               stall,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         s_bits,
  output logic               busy,
  output logic               done,
  output logic               start_err
);

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_ST1  = STATE1,
    S_ST2  = STATE2,
    S_ST3  = STATE3
  } state_t;

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    // Any start seen outside IDLE is rejected, including the last STATE3 cycle.
    err_d   = start && (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ST1;
          cnt_d   = dwell;
        end
      end
      // STATE1 is unconditional so STATE2 always follows an accepted start.
      S_ST1: state_d = S_ST2;
      S_ST2: begin
        if (abort)       state_d = S_IDLE;
        else if (!stall) state_d = S_ST3;
      end
      S_ST3: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (stall) begin
          state_d = S_ST3;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign s_bits    = state_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign start_err = err_q;

`ifdef START_SEQ_CTRL_ASSERT_EN
  a_start_seq : assert property (@(posedge clk) disable iff (rst)
    (start && s_bits == IDLE) |=> (s_bits == STATE1) ##1 (s_bits == STATE2));
  a_st1_to_st2 : assert property (@(posedge clk) disable iff (rst)
    (s_bits == STATE1) |=> (s_bits == STATE2));
  a_done_idle : assert property (@(posedge clk) disable iff (rst)
    done |-> (s_bits == IDLE));
  a_err_busy : assert property (@(posedge clk) disable iff (rst)
    $rose(start_err) |-> $past(busy));
  c_dwell3 : cover property (@(posedge clk) disable iff (rst)
    (start && s_bits == IDLE && dwell == DWELL_W'(3)) ##1 (s_bits == STATE1)
    ##1 (s_bits == STATE2) ##1 (s_bits == STATE3) [*4] ##1 done);
`else
`endif

endmodule

// File: tb/tb_start_seq_ctrl.sv
// tb/tb_start_seq_ctrl.sv - randomized and directed bench for start_seq_ctrl

module tb_start_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, stall;
  logic [3:0] dwell;
  logic [1:0] s_bits;
  logic       busy, done, start_err;

  int checks = 0;
  int errors = 0;

  // Reference model: the remaining expected s_bits values of the active
  // sequence; the head is the value currently on the bus.
  int mq[$];
  bit m_done, m_err;

  start_seq_ctrl #(.DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
    .dwell(dwell), .s_bits(s_bits), .busy(busy), .done(done),
    .start_err(start_err)
  );

  always #5 clk = ~clk;

  wire [4:0] got = {s_bits, busy, done, start_err};

  function automatic logic [4:0] exp_vec();
    logic [1:0] s;
    s = (mq.size() != 0) ? 2'(mq[0]) : 2'b00;
    return {s, mq.size() != 0, m_done, m_err};
  endfunction

  task automatic step(input bit r, input bit s, input bit a, input bit st,
                      input logic [3:0] d);
    int head;
    rst = r; start = s; abort = a; stall = st; dwell = d;
    m_done = 0;
    m_err  = 0;
    if (r) begin
      mq.delete();
    end else if (mq.size() == 0) begin
      if (s) begin
        mq.push_back(1);
        mq.push_back(2);
        for (int k = 0; k <= int'(d); k++) mq.push_back(3);
      end
    end else begin
      m_err = s;
      head  = mq[0];
      if (head != 1 && a) begin
        mq.delete();
      end else if (!(head != 1 && st)) begin
        void'(mq.pop_front());
        if (head == 3 && mq.size() == 0) m_done = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    checks++;
    if (got !== 5'b00000) begin
      errors++;
      $display("FAIL reset: got %b expected %b", got, 5'b00000);
    end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_basic();
    logic [4:0] tbl [4];
    int nbusy;
    tbl[0] = 5'b01100; tbl[1] = 5'b10100; tbl[2] = 5'b11100; tbl[3] = 5'b00010;
    nbusy = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, i == 0, 0, 0, 0);
      if (busy) nbusy++;
      checks++;
      if (i < 4 && got !== tbl[i]) begin
        errors++;
        $display("FAIL basic cyc%0d: got %b expected %b", i, got, tbl[i]);
      end
    end
    checks++;
    if (nbusy != 3) begin
      errors++;
      $display("FAIL basic_busy_len: got %0d expected 3", nbusy);
    end
  endtask

  task automatic test_dwell3();
    int nbusy, ndone, nst3;
    nbusy = 0; ndone = 0; nst3 = 0;
    for (int i = 0; i < 9; i++) begin
      step(0, i == 0, 0, 0, 3);
      nbusy += int'(busy); ndone += int'(done); nst3 += int'(s_bits == 2'b11);
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL dwell3 cyc%0d: got %b expected %b", i, got, exp_vec());
      end
    end
    checks++;
    if (nbusy != 6 || ndone != 1 || nst3 != 4) begin
      errors++;
      $display("FAIL dwell3_len: got busy %0d done %0d st3 %0d expected 6 1 4",
               nbusy, ndone, nst3);
    end
  endtask

  task automatic test_stall();
    int n2, n3, ndone;
    n2 = 0; n3 = 0; ndone = 0;
    step(0, 1, 0, 0, 2);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, (i == 1 || i == 2 || i == 4), 2);
      n2 += int'(s_bits == 2'b10); n3 += int'(s_bits == 2'b11);
      ndone += int'(done);
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL stall cyc%0d: got %b expected %b", i, got, exp_vec());
      end
    end
    checks++;
    if (n2 != 3 || n3 != 4 || ndone != 1) begin
      errors++;
      $display("FAIL stall_len: got st2 %0d st3 %0d done %0d expected 3 4 1",
               n2, n3, ndone);
    end
  endtask

  task automatic test_abort();
    step(0, 1, 0, 0, 3);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, (i == 0 || i == 3), 0, 3);
      checks++;
      if (got !== exp_vec() || (i == 0 && s_bits !== 2'b10) ||
          (i == 3 && got !== 5'b00000)) begin
        errors++;
        $display("FAIL abort cyc%0d: got %b expected %b", i, got, exp_vec());
      end
    end
  endtask

  task automatic test_start_err();
    int nerr;
    nerr = 0;
    step(0, 1, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      step(0, (i == 1 || i == 3 || i == 4), 0, 0, 1);
      nerr += int'(start_err);
      checks++;
      if (got !== exp_vec() || (i == 3 && got !== 5'b00011) ||
          (i == 4 && got !== 5'b01100)) begin
        errors++;
        $display("FAIL start_err cyc%0d: got %b expected %b", i, got, exp_vec());
      end
    end
    checks++;
    if (nerr != 2) begin
      errors++;
      $display("FAIL start_err_count: got %0d expected 2", nerr);
    end
  endtask

  task automatic test_back_to_back();
    int ndone, nerr;
    ndone = 0; nerr = 0;
    for (int i = 0; i < 14; i++) begin
      step(0, (i % 4 == 0) && i < 12, 0, 0, 0);
      ndone += int'(done); nerr += int'(start_err);
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL b2b cyc%0d: got %b expected %b", i, got, exp_vec());
      end
    end
    checks++;
    if (ndone != 3 || nerr != 0) begin
      errors++;
      $display("FAIL b2b_count: got done %0d err %0d expected 3 0", ndone, nerr);
    end
  endtask

  task automatic test_rst_mid();
    step(0, 1, 0, 0, 5);
    step(0, 0, 0, 0, 5);
    step(0, 1, 0, 0, 5);
    step(0, 1, 0, 0, 5);
    step(1, 1, 0, 0, 5);
    checks++;
    if (got !== 5'b00000) begin
      errors++;
      $display("FAIL rst_mid: got %b expected %b", got, 5'b00000);
    end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 30),
           ($urandom_range(99) < 8), ($urandom_range(99) < 25),
           4'($urandom_range(15)));
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc%0d: got %b expected %b", i, got, exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; stall = 0; dwell = '0;
    test_reset();
    test_basic();
    test_dwell3();
    test_stall();
    test_abort();
    test_start_err();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
